// File: rtl/event_frame_parser.sv
// event_frame_parser
//   Read-side consumer of the event data FIFO. Pops 32-bit event frame words,
//   checks the framing (event header, per-column header/data/footer, event
//   footer) and emits channel-pair samples plus event bookkeeping.
//
//   Latency: FIFO_RD_EN in cycle t, FIFO_DOUT consumed at the end of t+1,
//   registered outputs visible in t+2.
//
//   Optional feature macro: EVNUM_SEQ_CHECK_EN
//     When defined, the col-0 event number is checked against the last
//     completed event number + 1 (error code 4, non-fatal).
//
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   ENABLE, FIFO_EMPTY  read permission / FIFO status
//   FIFO_DOUT           FIFO read data (valid one cycle after FIFO_RD_EN)
//   FIFO_RD_EN          FIFO pop (combinational)
//   SAMPLE_*            decoded data word, PAIR_ID/COL_ID/EVENT_NUMBER tags
//   COL_HDR, COL_FTR    latched column header / footer half-words
//   COL_DONE, EVENT_DONE, ERR/ERR_CODE  single-cycle pulses
//   EVENT_CNT, ERR_CNT  good-event (wrapping) / error (saturating) counters
module event_frame_parser #(
  parameter int          NCOL      = 48,
  parameter int          NPAIR     = 8,
  parameter logic [31:0] EVENT_HDR = 32'hAAAAAAAA,
  parameter logic [31:0] EVENT_FTR = 32'hF0F0F0F0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ENABLE,
  input  logic        FIFO_EMPTY,
  input  logic [31:0] FIFO_DOUT,
  output logic        FIFO_RD_EN,
  output logic        SAMPLE_VALID,
  output logic [15:0] SAMPLE_LO,
  output logic [15:0] SAMPLE_HI,
  output logic [2:0]  PAIR_ID,
  output logic [5:0]  COL_ID,
  output logic [15:0] EVENT_NUMBER,
  output logic [15:0] COL_HDR,
  output logic [15:0] COL_FTR,
  output logic        COL_DONE,
  output logic        EVENT_DONE,
  output logic        ERR,
  output logic [2:0]  ERR_CODE,
  output logic [15:0] EVENT_CNT,
  output logic [15:0] ERR_CNT
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLHDR, S_DATA, S_COLFTR, S_EVTFTR
  } state_t;

  state_t      r_state;
  logic        r_vld;     // FIFO_RD_EN delayed: FIFO_DOUT holds a popped word
  logic [5:0]  r_col;
  logic [2:0]  r_pair;
`ifdef EVNUM_SEQ_CHECK_EN
  logic        r_seen;    // at least one event completed since reset
  logic [15:0] r_last;    // number of the last completed event
`endif

  logic [15:0] w_hi;
  logic [15:0] w_evn;
  logic        w_is_hdr;
  logic        w_last_col;
  logic        w_last_pair;
  logic        w_ftr_ok;
  logic [15:0] w_err_inc;

  assign FIFO_RD_EN  = ENABLE & ~FIFO_EMPTY;
  assign w_hi        = FIFO_DOUT[31:16];
  assign w_evn       = FIFO_DOUT[15:0];
  assign w_is_hdr    = (FIFO_DOUT == EVENT_HDR);
  assign w_last_col  = (r_col == 6'(NCOL - 1));
  assign w_last_pair = (r_pair == 3'(NPAIR - 1));
  assign w_ftr_ok    = (FIFO_DOUT[15:6] == 10'h0) && (FIFO_DOUT[5:0] == r_col);
  assign w_err_inc   = (ERR_CNT == 16'hFFFF) ? ERR_CNT : ERR_CNT + 16'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_vld        <= 1'b0;
      r_col        <= '0;
      r_pair       <= '0;
`ifdef EVNUM_SEQ_CHECK_EN
      r_seen       <= 1'b0;
      r_last       <= '0;
`endif
      SAMPLE_VALID <= 1'b0;
      SAMPLE_LO    <= '0;
      SAMPLE_HI    <= '0;
      PAIR_ID      <= '0;
      COL_ID       <= '0;
      EVENT_NUMBER <= '0;
      COL_HDR      <= '0;
      COL_FTR      <= '0;
      COL_DONE     <= 1'b0;
      EVENT_DONE   <= 1'b0;
      ERR          <= 1'b0;
      ERR_CODE     <= '0;
      EVENT_CNT    <= '0;
      ERR_CNT      <= '0;
    end else begin
      SAMPLE_VALID <= 1'b0;
      COL_DONE     <= 1'b0;
      EVENT_DONE   <= 1'b0;
      ERR          <= 1'b0;
      r_vld        <= FIFO_RD_EN;
      if (r_vld) begin
        case (r_state)
          S_IDLE: begin
            if (w_is_hdr) begin
              r_state <= S_COLHDR;
              r_col   <= '0;
            end
          end
          S_COLHDR: begin
            if (r_col == '0) begin
              EVENT_NUMBER <= w_evn;
              COL_HDR      <= w_hi;
              COL_ID       <= r_col;
              r_pair       <= '0;
              r_state      <= S_DATA;
`ifdef EVNUM_SEQ_CHECK_EN
              // Sequence gap is reported but the event keeps parsing.
              if (r_seen && (w_evn != r_last + 16'd1)) begin
                ERR      <= 1'b1;
                ERR_CODE <= 3'd4;
                ERR_CNT  <= w_err_inc;
              end
`endif
            end else if (w_is_hdr) begin
              // Premature event header wins over an evnum mismatch: restart
              // the frame with this word as the new event header.
              ERR      <= 1'b1;
              ERR_CODE <= 3'd5;
              ERR_CNT  <= w_err_inc;
              COL_ID   <= '0;
              r_col    <= '0;
            end else if (w_evn != EVENT_NUMBER) begin
              ERR      <= 1'b1;
              ERR_CODE <= 3'd1;
              ERR_CNT  <= w_err_inc;
              r_state  <= S_IDLE;
            end else begin
              COL_HDR <= w_hi;
              COL_ID  <= r_col;
              r_pair  <= '0;
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            // Data words are opaque: never matched against header/footer.
            SAMPLE_VALID <= 1'b1;
            SAMPLE_LO    <= FIFO_DOUT[15:0];
            SAMPLE_HI    <= FIFO_DOUT[31:16];
            PAIR_ID      <= r_pair;
            COL_ID       <= r_col;
            if (w_last_pair) r_state <= S_COLFTR;
            else             r_pair  <= r_pair + 3'd1;
          end
          S_COLFTR: begin
            if (!w_ftr_ok) begin
              ERR      <= 1'b1;
              ERR_CODE <= 3'd2;
              ERR_CNT  <= w_err_inc;
              r_state  <= S_IDLE;
            end else begin
              COL_FTR  <= w_hi;
              COL_DONE <= 1'b1;
              COL_ID   <= r_col;
              if (w_last_col) begin
                r_state <= S_EVTFTR;
              end else begin
                r_col   <= r_col + 6'd1;
                r_state <= S_COLHDR;
              end
            end
          end
          S_EVTFTR: begin
            if (FIFO_DOUT == EVENT_FTR) begin
              EVENT_DONE <= 1'b1;
              EVENT_CNT  <= EVENT_CNT + 16'd1;
`ifdef EVNUM_SEQ_CHECK_EN
              r_seen     <= 1'b1;
              r_last     <= EVENT_NUMBER;
`endif
            end else begin
              ERR      <= 1'b1;
              ERR_CODE <= 3'd3;
              ERR_CNT  <= w_err_inc;
            end
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_event_frame_parser.sv
// tb_event_frame_parser
//   Builds event frames word by word into a FIFO model. While a frame is
//   built, the expected output pulses (samples, column done, event done,
//   errors) are derived from what was deliberately put into it and queued.
//   A negedge monitor pops and compares every DUT pulse. A table of event
//   scenarios checks the counters after each one; hand-written phases cover
//   FIFO stalls, ENABLE gaps and reset in the middle of an event.
module tb_event_frame_parser;
  localparam int          NCOL  = 48;
  localparam int          NPAIR = 8;
  localparam logic [31:0] HDR   = 32'hAAAAAAAA;
  localparam logic [31:0] FTR   = 32'hF0F0F0F0;
`ifdef EVNUM_SEQ_CHECK_EN
  localparam int SEQ = 1;
`else
  localparam int SEQ = 0;
`endif

  logic        CLK, RST_N, ENABLE, FIFO_EMPTY, FIFO_RD_EN;
  logic [31:0] FIFO_DOUT;
  logic        SAMPLE_VALID, COL_DONE, EVENT_DONE, ERR;
  logic [15:0] SAMPLE_LO, SAMPLE_HI, EVENT_NUMBER, COL_HDR, COL_FTR, EVENT_CNT, ERR_CNT;
  logic [2:0]  PAIR_ID, ERR_CODE;
  logic [5:0]  COL_ID;

  event_frame_parser #(.NCOL(NCOL), .NPAIR(NPAIR), .EVENT_HDR(HDR), .EVENT_FTR(FTR)) dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_DOUT(FIFO_DOUT), .FIFO_RD_EN(FIFO_RD_EN), .SAMPLE_VALID(SAMPLE_VALID),
    .SAMPLE_LO(SAMPLE_LO), .SAMPLE_HI(SAMPLE_HI), .PAIR_ID(PAIR_ID), .COL_ID(COL_ID),
    .EVENT_NUMBER(EVENT_NUMBER), .COL_HDR(COL_HDR), .COL_FTR(COL_FTR),
    .COL_DONE(COL_DONE), .EVENT_DONE(EVENT_DONE), .ERR(ERR), .ERR_CODE(ERR_CODE),
    .EVENT_CNT(EVENT_CNT), .ERR_CNT(ERR_CNT));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] hi; logic [15:0] lo; logic [2:0] pair; logic [5:0] col; logic [15:0] evn;
  } smp_t;

  logic [31:0] fifo_q[$];
  smp_t        exp_s[$];
  logic [37:0] exp_c[$];   // {col, col_hdr, col_ftr}
  logic [31:0] exp_e[$];   // {evnum, event_cnt}
  logic [18:0] exp_r[$];   // {err_code, err_cnt}

  int n_checks = 0, n_errs = 0, n_samples = 0;
  int stall = 0;
  bit en = 1'b0;

  // reference bookkeeping
  logic [15:0] m_evcnt = 0, m_errcnt = 0, m_last = 0;
  bit          m_seen = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    n_checks++;
    n_errs++;
    $display("FAIL %s: got unexpected pulse expected none", name);
  endtask

  // FIFO model: pop on RD_EN, present the word one cycle later.
  initial begin
    bit          popped, tog;
    logic [31:0] w;
    FIFO_DOUT = '0; FIFO_EMPTY = 1'b1; ENABLE = 1'b0; tog = 1'b0; w = '0;
    forever begin
      @(posedge CLK);
      popped = FIFO_RD_EN && (fifo_q.size() > 0);
      if (popped) w = fifo_q.pop_front();
      #1;
      FIFO_DOUT = popped ? w : $urandom();
      tog = ~tog;
      FIFO_EMPTY = (fifo_q.size() == 0) ||
                   (stall == 1 && tog) || (stall == 2 && $urandom_range(0, 3) == 0);
      ENABLE = en;
    end
  end

  // Output monitor
  initial forever begin
    @(negedge CLK);
    if (RST_N) begin
      if (SAMPLE_VALID) begin
        n_samples++;
        if (exp_s.size() == 0) miss("sample_extra");
        else chk("sample", {SAMPLE_HI, SAMPLE_LO, PAIR_ID, COL_ID, EVENT_NUMBER}, exp_s.pop_front());
      end
      if (COL_DONE) begin
        if (exp_c.size() == 0) miss("coldone_extra");
        else chk("col_done", {COL_ID, COL_HDR, COL_FTR}, exp_c.pop_front());
      end
      if (EVENT_DONE) begin
        if (exp_e.size() == 0) miss("evdone_extra");
        else chk("event_done", {EVENT_NUMBER, EVENT_CNT}, exp_e.pop_front());
      end
      if (ERR) begin
        if (exp_r.size() == 0) miss("err_extra");
        else chk("err", {ERR_CODE, ERR_CNT}, exp_r.pop_front());
      end
    end
  end

  task automatic exp_err(input logic [2:0] code);
    if (m_errcnt != 16'hFFFF) m_errcnt++;
    exp_r.push_back({code, m_errcnt});
  endtask

  task automatic model_col0(input logic [15:0] evn);
`ifdef EVNUM_SEQ_CHECK_EN
    if (m_seen && evn != 16'(m_last + 16'd1)) exp_err(3'd4);
`endif
  endtask

  // kind: 0 clean, 1 evnum mismatch at col bad (alt), 2 bad footer index at
  // col bad, 3 bad event footer, 5 event header in place of col bad header,
  // followed by a full new event body with number alt.
  task automatic gen_event(input int kind, input int bad, input logic [15:0] evn,
                           input logic [15:0] alt);
    bit          dead = 0;
    int          c = 0;
    logic [15:0] h16, f16;
    logic [31:0] dw;
    logic [5:0]  idx;
    fifo_q.push_back(HDR);
    while (c < NCOL) begin
      if (c == 0 && !dead) model_col0(evn);
      if (kind == 5 && c == bad) begin
        fifo_q.push_back(HDR);
        exp_err(3'd5);
        kind = 0; evn = alt; c = 0;
        continue;
      end
      h16 = 16'hC000 | 16'(c);
      f16 = 16'hD000 | 16'(c);
      fifo_q.push_back({h16, (kind == 1 && c == bad) ? alt : evn});
      if (!dead && kind == 1 && c == bad) begin exp_err(3'd1); dead = 1; end
      for (int p = 0; p < NPAIR; p++) begin
        dw = $urandom();
        if (dw == HDR) dw = dw ^ 32'h1;
        fifo_q.push_back(dw);
        if (!dead) exp_s.push_back('{dw[31:16], dw[15:0], 3'(p), 6'(c), evn});
      end
      idx = (kind == 2 && c == bad) ? 6'(c + 1) : 6'(c);
      fifo_q.push_back({f16, 10'h0, idx});
      if (!dead) begin
        if (kind == 2 && c == bad) begin exp_err(3'd2); dead = 1; end
        else exp_c.push_back({6'(c), h16, f16});
      end
      c++;
    end
    fifo_q.push_back(kind == 3 ? ~FTR : FTR);
    if (!dead) begin
      if (kind == 3) exp_err(3'd3);
      else begin
        m_evcnt++; m_last = evn; m_seen = 1;
        exp_e.push_back({evn, m_evcnt});
      end
    end
  endtask

  task automatic garbage(input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom();
      if (w == HDR) w = 32'h0;
      fifo_q.push_back(w);
    end
  endtask

  task automatic drain();
    int cyc = 0;
    while ((fifo_q.size() + exp_s.size() + exp_c.size() + exp_e.size() + exp_r.size()) != 0
           && cyc < 20000) begin
      @(posedge CLK); cyc++;
    end
    repeat (4) @(posedge CLK);
    #2;
    chk("drain_leftover",
        128'(fifo_q.size() + exp_s.size() + exp_c.size() + exp_e.size() + exp_r.size()), 128'd0);
  endtask

  task automatic wait_samples(input int n);
    int cyc = 0;
    while (n_samples < n && cyc < 20000) begin @(posedge CLK); cyc++; end
    chk("wait_samples", 128'(n_samples >= n), 128'd1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {SAMPLE_VALID, SAMPLE_LO, SAMPLE_HI, PAIR_ID, COL_ID, EVENT_NUMBER, COL_HDR,
               COL_FTR, COL_DONE, EVENT_DONE, ERR, ERR_CODE, EVENT_CNT, ERR_CNT}, 128'd0);
  endtask

  typedef struct {
    int kind; int bad; logic [15:0] evn; logic [15:0] alt; int garb; int stl;
    logic [15:0] exp_ev; logic [15:0] exp_err;
  } vec_t;

  initial begin
    vec_t tbl[12];
    int   base, kinds[6];
    logic [15:0] evn;
    tbl[0]  = '{0,  0, 16'd1,    16'd0, 0, 0, 16'd1, 16'd0};
    tbl[1]  = '{0,  0, 16'd2,    16'd0, 5, 0, 16'd2, 16'd0};
    tbl[2]  = '{2,  5, 16'd3,    16'd0, 0, 0, 16'd2, 16'd1};
    tbl[3]  = '{0,  0, 16'd3,    16'd0, 0, 2, 16'd3, 16'd1};
    tbl[4]  = '{1, 10, 16'd4,    16'd5, 0, 0, 16'd3, 16'd2};
    tbl[5]  = '{5, 20, 16'd4,    16'd4, 0, 0, 16'd4, 16'd3};
    tbl[6]  = '{3,  0, 16'd5,    16'd0, 0, 0, 16'd4, 16'd4};
    tbl[7]  = '{0,  0, 16'd5,    16'd0, 0, 0, 16'd5, 16'd4};
    tbl[8]  = '{0,  0, 16'd7,    16'd0, 0, 0, 16'd6, 16'(4 + SEQ)};
    tbl[9]  = '{0,  0, 16'd8,    16'd0, 0, 2, 16'd7, 16'(4 + SEQ)};
    tbl[10] = '{0,  0, 16'hFFFF, 16'd0, 0, 0, 16'd8, 16'(4 + 2 * SEQ)};
    tbl[11] = '{0,  0, 16'h0000, 16'd0, 0, 0, 16'd9, 16'(4 + 2 * SEQ)};
    kinds = '{0, 1, 2, 3, 5, 0};

    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    chk_reset_outputs("reset_outputs");
    RST_N = 1'b1;
    en = 1'b1;

    for (int i = 0; i < 12; i++) begin
      stall = tbl[i].stl;
      garbage(tbl[i].garb);
      gen_event(tbl[i].kind, tbl[i].bad, tbl[i].evn, tbl[i].alt);
      drain();
      chk($sformatf("vec%0d_event_cnt", i), 128'(EVENT_CNT), 128'(tbl[i].exp_ev));
      chk($sformatf("vec%0d_err_cnt", i), 128'(ERR_CNT), 128'(tbl[i].exp_err));
    end

    // FIFO_EMPTY toggling every cycle, ENABLE dropped 20 cycles mid-column
    stall = 1;
    base = n_samples;
    gen_event(0, 0, 16'(m_last + 16'd1), 16'd0);
    gen_event(0, 0, 16'(m_last + 16'd1), 16'd0);
    wait_samples(base + 100);
    en = 1'b0;
    repeat (20) @(posedge CLK);
    en = 1'b1;
    drain();
    chk("stall_event_cnt", 128'(EVENT_CNT), 128'(m_evcnt));

    // randomized mix of frames and stalls
    stall = 2;
    for (int i = 0; i < 6; i++) begin
      evn = ($urandom_range(0, 3) == 0) ? 16'($urandom()) : 16'(m_last + 16'd1);
      garbage($urandom_range(0, 3));
      gen_event(kinds[$urandom_range(0, 5)], $urandom_range(1, NCOL - 1), evn,
                16'(evn + 16'h0101));
    end
    drain();
    chk("rand_event_cnt", 128'(EVENT_CNT), 128'(m_evcnt));
    chk("rand_err_cnt", 128'(ERR_CNT), 128'(m_errcnt));

    // reset at column 20 of an event; rest of that event stays in the FIFO
    stall = 0;
    base = n_samples;
    gen_event(0, 0, 16'(m_last + 16'd1), 16'd0);
    wait_samples(base + 20 * NPAIR + 2);
    #2;
    RST_N = 1'b0;
    exp_s.delete(); exp_c.delete(); exp_e.delete(); exp_r.delete();
    m_evcnt = 0; m_errcnt = 0; m_last = 0; m_seen = 0;
    #1;
    chk_reset_outputs("midevent_reset_outputs");
    repeat (2) @(posedge CLK);
    #2;
    RST_N = 1'b1;
    gen_event(0, 0, 16'h1234, 16'd0);
    drain();
    chk("post_reset_event_cnt", 128'(EVENT_CNT), 128'd1);
    chk("post_reset_err_cnt", 128'(ERR_CNT), 128'd0);
    chk("post_reset_evnum", 128'(EVENT_NUMBER), 128'h1234);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/event_frame_parser.md
# event_frame_parser

Read-side consumer of the event data FIFO. Pops the 32-bit event frame stream written by the column data selector, validates framing, and emits per-column channel-pair samples plus event bookkeeping. Sits between the event FIFO read port and downstream readout/histogram logic, in the same 100 MHz domain.

## Interface

Parameters:
- NCOL, 48, columns (memory addresses) per event
- NPAIR, 8, data words (channel pairs) per column
- EVENT_HDR, 32'hAAAAAAAA, event header word
- EVENT_FTR, 32'hF0F0F0F0, event footer word

Ports:
- CLK  in  1  system clock; one clock domain, all logic on posedge CLK
- RST_N  in  1  asynchronous, active-low reset
- ENABLE  in  1  permits FIFO reads
- FIFO_EMPTY  in  1  event FIFO empty
- FIFO_DOUT  in  32  FIFO read data, valid 1 cycle after FIFO_RD_EN
- FIFO_RD_EN  out  1  FIFO pop; combinational = ENABLE & ~FIFO_EMPTY
- SAMPLE_VALID  out  1  one data word decoded
- SAMPLE_LO  out  16  odd channel (word bits 15:0)
- SAMPLE_HI  out  16  even channel (word bits 31:16)
- PAIR_ID  out  3  pair index 0..NPAIR-1 (pair 0 = ch1/ch2)
- COL_ID  out  6  current column 0..NCOL-1
- EVENT_NUMBER  out  16  event number of current event
- COL_HDR  out  16  column header half-word (word bits 31:16)
- COL_FTR  out  16  column footer half-word (word bits 31:16)
- COL_DONE  out  1  pulse, column footer validated
- EVENT_DONE  out  1  pulse, event footer validated
- ERR  out  1  pulse, error detected
- ERR_CODE  out  3  code, valid with ERR
- EVENT_CNT  out  16  good events, wraps
- ERR_CNT  out  16  errors, saturates at 16'hFFFF

## Operation

- Frame: EVENT_HDR; then per column c = 0..NCOL-1: {hdr16, evnum16}, NPAIR data words, {ftr16, 10'h0, c[5:0]}; then EVENT_FTR. That is 482 words at the default parameters.
- The word-valid flag is FIFO_RD_EN delayed 1 cycle. The FSM advances only on valid words.
- States and transitions:
  - IDLE: discard silently until a word equals EVENT_HDR; then go to COLHDR with col=0.
  - COLHDR: if col=0, latch evnum into EVENT_NUMBER. If col>0 and evnum differs from EVENT_NUMBER, raise error 1. If the word equals EVENT_HDR and col>0, raise error 5. Latch COL_HDR, then go to DATA with pair=0.
  - DATA: output the word as a sample. After pair NPAIR-1, go to COLFTR.
  - COLFTR: if bits[15:6] are not 0 or bits[5:0] are not col, raise error 2. Otherwise latch COL_FTR and pulse COL_DONE. If col=NCOL-1 go to EVTFTR; otherwise col+1 and go to COLHDR.
  - EVTFTR: if the word equals EVENT_FTR, pulse EVENT_DONE, EVENT_CNT+1, go to IDLE. Otherwise raise error 3.
- Error actions:
  - Codes 1, 2, 3: ERR pulse, ERR_CNT+1 (saturating), go to IDLE. No EVENT_DONE for that event.
  - Code 5 (premature event header): ERR pulse, ERR_CNT+1, then treat the word as a new EVENT_HDR and go to COLHDR with col=0.
  - Code 4: sequence gap, see Configuration.
- Data words are never compared against EVENT_HDR or EVENT_FTR.
- ENABLE low: FIFO_RD_EN drops the same cycle. A word already popped is still processed. FSM state is held.
- Reset values: all outputs 0, state IDLE. EVENT_NUMBER is 0 and the "first event seen" flag is cleared.
- Reset asserted mid-event clears everything immediately. The in-flight FIFO word is discarded, and parsing resumes only at the next EVENT_HDR.

## Timing

- RD_EN at cycle t, FIFO_DOUT captured at t+1, registered outputs at t+2. Fixed latency: 2 cycles.
- SAMPLE_VALID, COL_DONE, EVENT_DONE and ERR are single-cycle pulses aligned with the word that caused them.
- PAIR_ID, COL_ID and EVENT_NUMBER are valid in the same cycle as SAMPLE_VALID.
- EVENT_CNT and ERR_CNT update in the same cycle as their pulse.
- Sustained throughput is one word per cycle with no bubbles.
- If error 5 and error 1 coincide on one word, ERR_CODE reports 5.

## Configuration

- EVNUM_SEQ_CHECK_EN defined:
  - At the col-0 header, check evnum against the last completed event's number +1, with wrap 16'hFFFF to 16'h0000.
  - On mismatch: ERR pulse, ERR_CODE=4, ERR_CNT+1. Parsing continues and the event completes normally.
  - The check is skipped for the first event after reset.
- EVNUM_SEQ_CHECK_EN undefined: no sequence check, and code 4 is never produced.

## Test plan

- Clean event, evnum=1, data word = {col,pair,col,pair} pattern → 384 SAMPLE_VALID, 48 COL_DONE, 1 EVENT_DONE, EVENT_CNT=1, ERR_CNT=0, EVENT_NUMBER=16'h0001.
- 5 garbage words, then a clean event → garbage discarded silently, event parsed, ERR_CNT=0.
- Col 5 footer index = 6 → ERR, ERR_CODE=2, no EVENT_DONE. A following clean event gives EVENT_CNT=1, ERR_CNT=1.
- Event 2 with evnum=3 at col 10 header → ERR_CODE=1. Separately, EVENT_HDR at the col 20 header position → ERR_CODE=5, and the following 481 words parse as a good event.
- Events 1, 2, 4 → with EVNUM_SEQ_CHECK_EN: one ERR_CODE=4, EVENT_CNT=3, ERR_CNT=1. Without it: EVENT_CNT=3, ERR_CNT=0.
- FIFO_EMPTY toggled every cycle, ENABLE low 20 cycles mid-column, RST_N pulsed at col 20 of a later event → output sequence identical to the back-to-back case, no lost or duplicated words. Reset zeroes outputs immediately, and the next clean event gives EVENT_CNT=1.
